// File: rtl/mem_pkg.sv
// Shared types and helpers for the pipelined word RAM: response record,
// latency bound and the byte-lane merge used by masked writes.
package mem_pkg;

  localparam int unsigned MEM_MAX_LATENCY = 4;
  localparam int unsigned MEM_MAX_DATA_W  = 128;
  localparam int unsigned MEM_MAX_MASK_W  = MEM_MAX_DATA_W / 8;

  // Data field is sized for the widest supported word; narrower instances use the low bits.
  typedef struct packed {
    logic                      valid;
    logic                      err;
    logic [MEM_MAX_DATA_W-1:0] data;
  } mem_resp_t;

  function automatic logic [MEM_MAX_DATA_W-1:0] lane_merge(
    input logic [MEM_MAX_DATA_W-1:0] old_w,
    input logic [MEM_MAX_DATA_W-1:0] new_w,
    input logic [MEM_MAX_MASK_W-1:0] mask
  );
    logic [MEM_MAX_DATA_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MEM_MAX_MASK_W; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Delay line for responses: LATENCY-1 register stages behind the array read
// register, cleared asynchronously so in-flight responses vanish on reset.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  mem_resp_t i_resp,
  output mem_resp_t o_resp
);

  if (LATENCY <= 1) begin : g_pass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk | rst;
    assign o_resp = i_resp;
  end else begin : g_regs
    mem_resp_t r_stage [LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_resp;
        for (int unsigned i = 1; i < LATENCY - 1; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_resp = r_stage[LATENCY-2];
  end

endmodule

// File: rtl/memory_pipelined.sv
// Single-port word RAM with byte-lane writes and fixed-latency, in-order
// responses; one done pulse per request, range/illegal requests flagged on mem_err.
module memory_pipelined
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SIZE    = 256,
  parameter int unsigned LATENCY = 1,
  parameter string       INIT_F  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_wstrobe,
  input  logic                mem_rstrobe,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_done,
  output logic                mem_err
);

  localparam int unsigned OFF_B = $clog2(DATA_W / 8);
  localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1;

  if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY || (DATA_W % 8) != 0 ||
      DATA_W > MEM_MAX_DATA_W) begin : g_bad_params
    $error("memory_pipelined: unsupported LATENCY=%0d or DATA_W=%0d", LATENCY, DATA_W);
  end

  logic [DATA_W-1:0] r_mem [SIZE];

  logic          w_req;
  logic          w_both;
  logic          w_oor;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [AW-1:0] w_idx;
  mem_resp_t     r_resp0;
  mem_resp_t     w_resp_out;

  assign w_req   = mem_wstrobe | mem_rstrobe;
  assign w_both  = mem_wstrobe & mem_rstrobe;
  assign w_oor   = (mem_addr >> OFF_B) >= 32'(SIZE);
  assign w_idx   = mem_addr[OFF_B +: AW];
  // Writes are held off while reset is high so nothing is accepted during reset.
  assign w_wr_en = mem_wstrobe & ~mem_rstrobe & ~w_oor & ~rst;
  assign w_rd_en = mem_rstrobe & ~mem_wstrobe & ~w_oor;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= DATA_W'(lane_merge(MEM_MAX_DATA_W'(r_mem[w_idx]),
                                         MEM_MAX_DATA_W'(mem_wdata),
                                         MEM_MAX_MASK_W'(mem_wmask)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp0 <= '0;
    end else begin
      r_resp0.valid <= w_req;
      r_resp0.err   <= w_both | (w_req & w_oor);
      r_resp0.data  <= w_rd_en ? MEM_MAX_DATA_W'(r_mem[w_idx]) : '0;
    end
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_resp (r_resp0),
    .o_resp (w_resp_out)
  );

  assign mem_done  = w_resp_out.valid;
  assign mem_err   = w_resp_out.err;
  assign mem_rdata = DATA_W'(w_resp_out.data);

endmodule

// File: tb/tb_memory_pipelined.sv
// Directed bench for memory_pipelined: two instances (LATENCY 3 and 4) share
// stimulus; per-cycle outputs are captured on falling edges and checked per scenario.
module tb_memory_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        ws;
  logic        rs;
  logic [31:0] rd_a, rd_b;
  logic        done_a, err_a, done_b, err_b;

  int checks = 0;
  int errors = 0;

  logic        hd_a [0:11];
  logic        he_a [0:11];
  logic [31:0] hr_a [0:11];
  logic        hd_b [0:11];
  logic        he_b [0:11];
  logic [31:0] hr_b [0:11];

  always #5 clk = ~clk;

  memory_pipelined #(.DATA_W(32), .SIZE(256), .LATENCY(3), .INIT_F("")) u_dut_a (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata), .mem_wmask(wmask),
    .mem_wstrobe(ws), .mem_rstrobe(rs), .mem_rdata(rd_a), .mem_done(done_a), .mem_err(err_a)
  );

  memory_pipelined #(.DATA_W(32), .SIZE(256), .LATENCY(4), .INIT_F("")) u_dut_b (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata), .mem_wmask(wmask),
    .mem_wstrobe(ws), .mem_rstrobe(rs), .mem_rdata(rd_b), .mem_done(done_b), .mem_err(err_b)
  );

  task automatic set_req(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    ws = w; rs = r; addr = a; wdata = d; wmask = m;
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 12; k++) begin
      hd_a[k] = 1'b0; he_a[k] = 1'b0; hr_a[k] = '0;
      hd_b[k] = 1'b0; he_b[k] = 1'b0; hr_b[k] = '0;
    end
  endtask

  // Capture index k = k-th falling edge after the accept edge of the first request.
  task automatic cap(input int k);
    @(negedge clk);
    hd_a[k] = done_a; he_a[k] = err_a; hr_a[k] = rd_a;
    hd_b[k] = done_b; he_b[k] = err_b; hr_b[k] = rd_b;
  endtask

  task automatic single(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    clear_hist();
    @(negedge clk);
    set_req(w, r, a, d, m);
    cap(1);
    set_req(1'b0, 1'b0, '0, '0, '0);
    for (int k = 2; k < 8; k++) cap(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b want 0", done_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b want 0", err_a); end
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_rdata_a got %h want 0", rd_a); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b got %b want 0", done_b); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL reset_err_b got %b want 0", err_b); end
    checks++; if (rd_b !== 32'h0) begin errors++; $display("FAIL reset_rdata_b got %h want 0", rd_b); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    single(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (hd_a[2] !== 1'b0) begin errors++; $display("FAIL wr_early_done_a got %b want 0", hd_a[2]); end
    checks++; if (hd_a[3] !== 1'b1) begin errors++; $display("FAIL wr_done_a got %b want 1", hd_a[3]); end
    checks++; if (he_a[3] !== 1'b0) begin errors++; $display("FAIL wr_err_a got %b want 0", he_a[3]); end
    checks++; if (hr_a[3] !== 32'h0) begin errors++; $display("FAIL wr_rdata_a got %h want 0", hr_a[3]); end
    checks++; if (hd_b[3] !== 1'b0) begin errors++; $display("FAIL wr_early_done_b got %b want 0", hd_b[3]); end
    checks++; if (hd_b[4] !== 1'b1) begin errors++; $display("FAIL wr_done_b got %b want 1", hd_b[4]); end
    single(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    checks++; if (hd_a[3] !== 1'b1) begin errors++; $display("FAIL rd_done_a got %b want 1", hd_a[3]); end
    checks++; if (hr_a[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_a got %h want deadbeef", hr_a[3]); end
    checks++; if (he_a[3] !== 1'b0) begin errors++; $display("FAIL rd_err_a got %b want 0", he_a[3]); end
    checks++; if (hd_a[4] !== 1'b0) begin errors++; $display("FAIL rd_single_pulse_a got %b want 0", hd_a[4]); end
    checks++; if (hr_a[4] !== 32'h0) begin errors++; $display("FAIL rd_idle_rdata_a got %h want 0", hr_a[4]); end
    checks++; if (hd_b[4] !== 1'b1) begin errors++; $display("FAIL rd_done_b got %b want 1", hd_b[4]); end
    checks++; if (hr_b[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_b got %h want deadbeef", hr_b[4]); end
  endtask

  task automatic test_lane_merge();
    single(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF);
    single(1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101);
    single(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
    checks++; if (hr_a[3] !== 32'h11BB33DD) begin errors++; $display("FAIL merge_a got %h want 11bb33dd", hr_a[3]); end
    checks++; if (hr_b[4] !== 32'h11BB33DD) begin errors++; $display("FAIL merge_b got %h want 11bb33dd", hr_b[4]); end
    single(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0000);
    checks++; if (hd_a[3] !== 1'b1) begin errors++; $display("FAIL nomask_done_a got %b want 1", hd_a[3]); end
    single(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
    checks++; if (hr_a[3] !== 32'h11BB33DD) begin errors++; $display("FAIL nomask_data_a got %h want 11bb33dd", hr_a[3]); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    clear_hist();
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    cap(1);
    set_req(1'b1, 1'b0, 32'h10, 32'h12345678, 4'hF);
    cap(2);
    set_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    cap(3);
    set_req(1'b0, 1'b0, '0, '0, '0);
    for (int k = 4; k < 10; k++) cap(k);
    for (int k = 1; k < 9; k++) begin
      exp_d = (k >= 3 && k <= 5);
      checks++; if (hd_a[k] !== exp_d) begin errors++; $display("FAIL b2b_done_a[%0d] got %b want %b", k, hd_a[k], exp_d); end
    end
    checks++; if (hr_a[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd0_a got %h want deadbeef", hr_a[3]); end
    checks++; if (hr_a[4] !== 32'h0) begin errors++; $display("FAIL b2b_wr_a got %h want 0", hr_a[4]); end
    checks++; if (hr_a[5] !== 32'h12345678) begin errors++; $display("FAIL b2b_rd1_a got %h want 12345678", hr_a[5]); end
    checks++; if (hd_b[6] !== 1'b1) begin errors++; $display("FAIL b2b_done_b got %b want 1", hd_b[6]); end
    checks++; if (hr_b[6] !== 32'h12345678) begin errors++; $display("FAIL b2b_rd1_b got %h want 12345678", hr_b[6]); end
    checks++; if (hd_b[7] !== 1'b0) begin errors++; $display("FAIL b2b_tail_b got %b want 0", hd_b[7]); end
  endtask

  task automatic test_out_of_range();
    single(1'b1, 1'b0, 32'h0, 32'h0BADCAFE, 4'hF);
    single(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
    checks++; if (hd_a[3] !== 1'b1) begin errors++; $display("FAIL oor_rd_done_a got %b want 1", hd_a[3]); end
    checks++; if (he_a[3] !== 1'b1) begin errors++; $display("FAIL oor_rd_err_a got %b want 1", he_a[3]); end
    checks++; if (hr_a[3] !== 32'h0) begin errors++; $display("FAIL oor_rd_data_a got %h want 0", hr_a[3]); end
    checks++; if (he_b[4] !== 1'b1) begin errors++; $display("FAIL oor_rd_err_b got %b want 1", he_b[4]); end
    single(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 4'hF);
    checks++; if (he_a[3] !== 1'b1) begin errors++; $display("FAIL oor_wr_err_a got %b want 1", he_a[3]); end
    single(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    checks++; if (hr_a[3] !== 32'h0BADCAFE) begin errors++; $display("FAIL oor_alias_a got %h want 0badcafe", hr_a[3]); end
    checks++; if (he_a[3] !== 1'b0) begin errors++; $display("FAIL word0_err_a got %b want 0", he_a[3]); end
    single(1'b0, 1'b1, 32'h3FC, 32'h0, 4'h0);
    checks++; if (hd_a[3] !== 1'b1) begin errors++; $display("FAIL last_word_done_a got %b want 1", hd_a[3]); end
    checks++; if (he_a[3] !== 1'b0) begin errors++; $display("FAIL last_word_err_a got %b want 0", he_a[3]); end
  endtask

  task automatic test_both_strobes();
    single(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF);
    checks++; if (hd_a[3] !== 1'b1) begin errors++; $display("FAIL both_done_a got %b want 1", hd_a[3]); end
    checks++; if (he_a[3] !== 1'b1) begin errors++; $display("FAIL both_err_a got %b want 1", he_a[3]); end
    checks++; if (hr_a[3] !== 32'h0) begin errors++; $display("FAIL both_rdata_a got %h want 0", hr_a[3]); end
    single(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    checks++; if (hr_a[3] !== 32'h0BADCAFE) begin errors++; $display("FAIL both_unchanged_a got %h want 0badcafe", hr_a[3]); end
  endtask

  task automatic test_reset_mid();
    clear_hist();
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    cap(1);
    set_req(1'b0, 1'b0, '0, '0, '0);
    cap(2);
    rst = 1'b1;
    cap(3);
    cap(4);
    cap(5);
    rst = 1'b0;
    set_req(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    cap(6);
    set_req(1'b0, 1'b0, '0, '0, '0);
    for (int k = 7; k < 12; k++) cap(k);
    for (int k = 3; k < 9; k++) begin
      checks++; if (hd_b[k] !== 1'b0) begin errors++; $display("FAIL rstmid_done_b[%0d] got %b want 0", k, hd_b[k]); end
      checks++; if (hr_b[k] !== 32'h0 || he_b[k] !== 1'b0) begin errors++; $display("FAIL rstmid_out_b[%0d] got %h/%b want 0/0", k, hr_b[k], he_b[k]); end
    end
    checks++; if (hd_a[3] !== 1'b0) begin errors++; $display("FAIL rstmid_done_a got %b want 0", hd_a[3]); end
    checks++; if (hd_b[9] !== 1'b1) begin errors++; $display("FAIL rstmid_next_done_b got %b want 1", hd_b[9]); end
    checks++; if (hr_b[9] !== 32'h12345678) begin errors++; $display("FAIL rstmid_next_data_b got %h want 12345678", hr_b[9]); end
    checks++; if (he_b[9] !== 1'b0) begin errors++; $display("FAIL rstmid_next_err_b got %b want 0", he_b[9]); end
    checks++; if (hd_a[8] !== 1'b1 || hr_a[8] !== 32'h12345678) begin errors++; $display("FAIL rstmid_next_a got %b/%h want 1/12345678", hd_a[8], hr_a[8]); end
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_write_read();
    test_lane_merge();
    test_back_to_back();
    test_out_of_range();
    test_both_strobes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
